// File: rtl/vga_write_arbiter_if.sv
// Requester-side bus of the VGA write arbiter: per-requester request, pixel
// stream and the arbiter's grant/ready answer.
interface vga_write_arbiter_if;
    logic [2:0]  req;
    logic [2:0]  valid;
    logic [2:0]  last;
    logic [26:0] x_in;
    logic [23:0] y_in;
    logic [8:0]  color_in;
    logic [2:0]  grant;
    logic [2:0]  ready;

    modport master (output req, valid, last, x_in, y_in, color_in,
                    input  grant, ready);
    modport slave  (input  req, valid, last, x_in, y_in, color_in,
                    output grant, ready);
endinterface

// File: rtl/vga_write_arbiter.sv
// Round-robin arbiter feeding three pixel requesters into one VGA adapter write port.
// Latency: req->grant one edge, accepted pixel->writeEn one edge; ready = grant, no skid.
module vga_write_arbiter #(
    parameter int MAX_HOLD = 1024
) (
    input  logic                  clk,
    input  logic                  iReset,
    input  logic                  V_SYNC,
    vga_write_arbiter_if.slave    bus,
    output logic [8:0]            x,
    output logic [7:0]            y,
    output logic [2:0]            color,
    output logic                  writeEn,
    output logic                  frame_start,
    output logic                  busy
);
    localparam int             HW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0]  HOLD_TOP = HW'(MAX_HOLD - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    r_owner;
    logic [1:0]    r_last_owner;
    logic [HW-1:0] r_hold;
    logic          r_vsync;
    logic [8:0]    r_x;
    logic [7:0]    r_y;
    logic [2:0]    r_color;
    logic          r_we;

    logic [1:0]    w_sel;
    logic [1:0]    w_idx;
    logic          w_found;
    logic [2:0]    w_grant;
    logic          w_xfer;
    logic          w_last;
    logic          w_owner_req;
    logic          w_others;
    logic          w_hold_top;
    logic          w_leave;
    logic [8:0]    w_px;
    logic [7:0]    w_py;
    logic [2:0]    w_pc;
    logic          w_in_range;

    function automatic logic [1:0] next3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // Search starts just after the previous owner so every requester gets a turn.
    always_comb begin
        w_sel   = 2'd0;
        w_found = 1'b0;
        w_idx   = next3(r_last_owner);
        for (int k = 0; k < 3; k++) begin
            if (!w_found && bus.req[w_idx]) begin
                w_sel   = w_idx;
                w_found = 1'b1;
            end
            w_idx = next3(w_idx);
        end
    end

    always_comb begin
        w_px = bus.x_in[8:0];
        w_py = bus.y_in[7:0];
        w_pc = bus.color_in[2:0];
        case (r_owner)
            2'd1: begin
                w_px = bus.x_in[17:9];
                w_py = bus.y_in[15:8];
                w_pc = bus.color_in[5:3];
            end
            2'd2: begin
                w_px = bus.x_in[26:18];
                w_py = bus.y_in[23:16];
                w_pc = bus.color_in[8:6];
            end
            default: ;
        endcase
    end

    assign w_grant     = (r_state == S_GRANT) ? (3'b001 << r_owner) : 3'b000;
    assign w_xfer      = |(bus.valid & w_grant);
    assign w_last      = |(bus.last & w_grant);
    assign w_owner_req = |(bus.req & w_grant);
    assign w_others    = |(bus.req & ~w_grant);
    assign w_hold_top  = (r_hold == HOLD_TOP);
    assign w_leave     = (w_xfer & w_last) | ~w_owner_req | (w_hold_top & w_others);
    assign w_in_range  = (w_px <= 9'd319) && (w_py <= 8'd239);

    always_ff @(posedge clk) begin
        if (iReset) begin
            r_state      <= S_IDLE;
            r_owner      <= 2'd0;
            r_last_owner <= 2'd2;
            r_hold       <= '0;
            r_vsync      <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_color      <= '0;
            r_we         <= 1'b0;
        end else begin
            r_vsync <= V_SYNC;
            r_we    <= 1'b0;
            // Out-of-range pixels are still consumed; only the strobe is suppressed.
            if (w_xfer) begin
                r_x     <= w_px;
                r_y     <= w_py;
                r_color <= w_pc;
                r_we    <= w_in_range;
            end
            case (r_state)
                S_IDLE: begin
                    if (|bus.req) begin
                        r_state <= S_GRANT;
                        r_owner <= w_sel;
                        r_hold  <= '0;
                    end
                end
                S_GRANT: begin
                    if (!w_hold_top)
                        r_hold <= r_hold + 1'b1;
                    if (w_leave) begin
                        r_state      <= S_RELEASE;
                        r_last_owner <= r_owner;
                    end
                end
                S_RELEASE: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.grant   = w_grant;
    assign bus.ready   = w_grant;
    assign x           = r_x;
    assign y           = r_y;
    assign color       = r_color;
    assign writeEn     = r_we;
    assign frame_start = r_vsync & ~V_SYNC;
    assign busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_vga_write_arbiter.sv
// Bench for vga_write_arbiter (MAX_HOLD=4): vector table with a write scoreboard,
// plus hand sequences for V_SYNC edge detection and mid-transfer reset.
module tb_vga_write_arbiter;
    logic       clk = 1'b0;
    logic       iReset;
    logic       V_SYNC;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] color;
    logic       writeEn;
    logic       frame_start;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    vga_write_arbiter_if bus ();

    vga_write_arbiter #(.MAX_HOLD(4)) dut (
        .clk         (clk),
        .iReset      (iReset),
        .V_SYNC      (V_SYNC),
        .bus         (bus),
        .x           (x),
        .y           (y),
        .color       (color),
        .writeEn     (writeEn),
        .frame_start (frame_start),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  req, valid, last;
        logic [26:0] x_in;
        logic [23:0] y_in;
        logic [8:0]  color_in;
        logic [2:0]  eg;
        logic        eb;
        logic        ewe;
        logic [8:0]  ex;
        logic [7:0]  ey;
        logic [2:0]  ec;
    } vec_t;

    typedef struct {
        logic       we;
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } wr_t;

    localparam int NV = 29;
    vec_t vt [NV];
    wr_t  wr_q [$];

    // Non-selected slices carry a decoy pixel so a wrong slice select shows up.
    function automatic vec_t mk(input logic [2:0] r, v, l, input int who,
                                input logic [8:0] px, input logic [7:0] py, input logic [2:0] pc,
                                input logic [2:0] eg, input logic eb, input logic ewe,
                                input logic [8:0] ex, input logic [7:0] ey, input logic [2:0] ec);
        vec_t t;
        t.req = r; t.valid = v; t.last = l;
        for (int s = 0; s < 3; s++) begin
            t.x_in[9*s +: 9]     = (s == who) ? px : 9'd77;
            t.y_in[8*s +: 8]     = (s == who) ? py : 8'd88;
            t.color_in[3*s +: 3] = (s == who) ? pc : 3'd6;
        end
        t.eg = eg; t.eb = eb; t.ewe = ewe; t.ex = ex; t.ey = ey; t.ec = ec;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_write(input string tag);
        wr_t e;
        if (wr_q.size() == 0) begin
            chk({tag, " scoreboard empty"}, 32'd1, 32'd0);
        end else begin
            e = wr_q.pop_front();
            chk({tag, " writeEn"}, 32'(writeEn), 32'(e.we));
            chk({tag, " x"},       32'(x),       32'(e.x));
            chk({tag, " y"},       32'(y),       32'(e.y));
            chk({tag, " color"},   32'(color),   32'(e.c));
        end
    endtask

    task automatic set_pixel(input logic [2:0] r, v, l, input int who,
                             input logic [8:0] px, input logic [7:0] py, input logic [2:0] pc);
        vec_t t;
        t = mk(r, v, l, who, px, py, pc, 3'b0, 1'b0, 1'b0, 9'd0, 8'd0, 3'd0);
        bus.req = t.req; bus.valid = t.valid; bus.last = t.last;
        bus.x_in = t.x_in; bus.y_in = t.y_in; bus.color_in = t.color_in;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //            req     valid   last   who  x    y    c     grant  busy  we x    y    c
        vt[0]  = mk(3'b111, 3'b000, 3'b000, 0, 0,   0,   0,   3'b000, 0,   0, 0,   0,   0);
        vt[1]  = mk(3'b111, 3'b001, 3'b001, 0, 5,   6,   1,   3'b001, 1,   1, 5,   6,   1);
        vt[2]  = mk(3'b111, 3'b000, 3'b000, 0, 0,   0,   0,   3'b000, 1,   0, 5,   6,   1);
        vt[3]  = mk(3'b111, 3'b000, 3'b000, 0, 0,   0,   0,   3'b000, 0,   0, 5,   6,   1);
        vt[4]  = mk(3'b111, 3'b011, 3'b010, 1, 10,  20,  5,   3'b010, 1,   1, 10,  20,  5);
        vt[5]  = mk(3'b111, 3'b000, 3'b000, 0, 0,   0,   0,   3'b000, 1,   0, 10,  20,  5);
        vt[6]  = mk(3'b111, 3'b000, 3'b000, 0, 0,   0,   0,   3'b000, 0,   0, 10,  20,  5);
        vt[7]  = mk(3'b011, 3'b000, 3'b000, 0, 0,   0,   0,   3'b100, 1,   0, 10,  20,  5);
        vt[8]  = mk(3'b111, 3'b000, 3'b000, 0, 0,   0,   0,   3'b000, 1,   0, 10,  20,  5);
        vt[9]  = mk(3'b111, 3'b000, 3'b000, 0, 0,   0,   0,   3'b000, 0,   0, 10,  20,  5);
        vt[10] = mk(3'b001, 3'b001, 3'b000, 0, 320, 0,   7,   3'b001, 1,   0, 320, 0,   7);
        vt[11] = mk(3'b001, 3'b001, 3'b000, 0, 0,   240, 2,   3'b001, 1,   0, 0,   240, 2);
        vt[12] = mk(3'b001, 3'b001, 3'b000, 0, 319, 239, 3,   3'b001, 1,   1, 319, 239, 3);
        vt[13] = mk(3'b001, 3'b000, 3'b000, 0, 0,   0,   0,   3'b001, 1,   0, 319, 239, 3);
        vt[14] = mk(3'b101, 3'b001, 3'b000, 0, 1,   1,   1,   3'b001, 1,   1, 1,   1,   1);
        vt[15] = mk(3'b101, 3'b000, 3'b000, 0, 0,   0,   0,   3'b000, 1,   0, 1,   1,   1);
        vt[16] = mk(3'b101, 3'b000, 3'b000, 0, 0,   0,   0,   3'b000, 0,   0, 1,   1,   1);
        vt[17] = mk(3'b101, 3'b100, 3'b100, 2, 2,   3,   4,   3'b100, 1,   1, 2,   3,   4);
        vt[18] = mk(3'b001, 3'b000, 3'b000, 0, 0,   0,   0,   3'b000, 1,   0, 2,   3,   4);
        vt[19] = mk(3'b001, 3'b000, 3'b000, 0, 0,   0,   0,   3'b000, 0,   0, 2,   3,   4);
        vt[20] = mk(3'b101, 3'b001, 3'b000, 0, 20,  7,   6,   3'b001, 1,   1, 20,  7,   6);
        vt[21] = mk(3'b101, 3'b001, 3'b000, 0, 21,  7,   6,   3'b001, 1,   1, 21,  7,   6);
        vt[22] = mk(3'b101, 3'b001, 3'b000, 0, 22,  7,   6,   3'b001, 1,   1, 22,  7,   6);
        vt[23] = mk(3'b101, 3'b001, 3'b000, 0, 23,  7,   6,   3'b001, 1,   1, 23,  7,   6);
        vt[24] = mk(3'b101, 3'b001, 3'b000, 0, 99,  7,   6,   3'b000, 1,   0, 23,  7,   6);
        vt[25] = mk(3'b101, 3'b000, 3'b000, 0, 0,   0,   0,   3'b000, 0,   0, 23,  7,   6);
        vt[26] = mk(3'b000, 3'b000, 3'b000, 0, 0,   0,   0,   3'b100, 1,   0, 23,  7,   6);
        vt[27] = mk(3'b000, 3'b000, 3'b000, 0, 0,   0,   0,   3'b000, 1,   0, 23,  7,   6);
        vt[28] = mk(3'b000, 3'b000, 3'b000, 0, 0,   0,   0,   3'b000, 0,   0, 23,  7,   6);

        iReset = 1'b1;
        V_SYNC = 1'b1;
        set_pixel(3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
        repeat (2) @(posedge clk);

        // Reset values are what the first table sample must show.
        wr_q.push_back('{we: 1'b0, x: 9'd0, y: 8'd0, c: 3'd0});
        for (int i = 0; i < NV; i++) begin
            next_edge();
            iReset       = 1'b0;
            bus.req      = vt[i].req;
            bus.valid    = vt[i].valid;
            bus.last     = vt[i].last;
            bus.x_in     = vt[i].x_in;
            bus.y_in     = vt[i].y_in;
            bus.color_in = vt[i].color_in;
            @(negedge clk);
            chk($sformatf("row%0d grant", i), 32'(bus.grant), 32'(vt[i].eg));
            chk($sformatf("row%0d ready", i), 32'(bus.ready), 32'(vt[i].eg));
            chk($sformatf("row%0d busy", i),  32'(busy),      32'(vt[i].eb));
            if (i == 0)
                chk("reset frame_start", 32'(frame_start), 32'd0);
            pop_write($sformatf("row%0d", i));
            wr_q.push_back('{we: vt[i].ewe, x: vt[i].ex, y: vt[i].ey, c: vt[i].ec});
        end
        next_edge();
        set_pixel(3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
        @(negedge clk);
        pop_write("tail");

        // V_SYNC falling edge: a single pulse, none while held low or on rise.
        next_edge();
        V_SYNC = 1'b0;
        @(negedge clk);
        chk("vsync fall pulse", 32'(frame_start), 32'd1);
        next_edge();
        @(negedge clk);
        chk("vsync held low 1", 32'(frame_start), 32'd0);
        next_edge();
        @(negedge clk);
        chk("vsync held low 2", 32'(frame_start), 32'd0);
        next_edge();
        V_SYNC = 1'b1;
        @(negedge clk);
        chk("vsync rise", 32'(frame_start), 32'd0);

        // Reset while owner 0 is handing over an in-range pixel.
        next_edge();
        set_pixel(3'b001, 3'b000, 3'b000, 0, 0, 0, 0);
        @(negedge clk);
        chk("pre-reset idle grant", 32'(bus.grant), 32'd0);
        next_edge();
        set_pixel(3'b001, 3'b001, 3'b000, 0, 30, 30, 1);
        iReset = 1'b1;
        @(negedge clk);
        chk("pre-reset grant", 32'(bus.grant), 32'b001);
        chk("pre-reset ready", 32'(bus.ready), 32'b001);
        next_edge();
        iReset = 1'b0;
        set_pixel(3'b111, 3'b000, 3'b000, 0, 0, 0, 0);
        @(negedge clk);
        chk("post-reset writeEn", 32'(writeEn), 32'd0);
        chk("post-reset grant",   32'(bus.grant), 32'd0);
        chk("post-reset x",       32'(x), 32'd0);
        chk("post-reset busy",    32'(busy), 32'd0);
        next_edge();
        @(negedge clk);
        chk("post-reset first owner", 32'(bus.grant), 32'b001);
        chk("post-reset writeEn idle", 32'(writeEn), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
